// File: rtl/if_stage_pkg.sv
// Shared defaults and FSM state encoding for the instruction-fetch stage.
package if_stage_pkg;
  localparam int                    PC_W_DEF     = 12;
  localparam int                    INSTR_W_DEF  = 16;
  localparam logic [PC_W_DEF-1:0]   RESET_PC_DEF = 12'h000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: clear > hold > load; with none of them asserted it takes a bubble.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_hold,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);
  logic               r_vld_p1;
  logic [INSTR_W-1:0] r_instr_p1;
  logic [PC_W-1:0]    r_pc_p1;

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_instr_p1 <= '0;
      r_pc_p1    <= '0;
    end else if (i_clear) begin
      r_vld_p1   <= 1'b0;
    end else if (i_hold) begin
      r_vld_p1   <= r_vld_p1;
    end else if (i_load) begin
      r_vld_p1   <= 1'b1;
      r_instr_p1 <= i_instr;
      r_pc_p1    <= i_pc;
    end else begin
      r_vld_p1   <= 1'b0;
    end
  end

  assign o_valid = r_vld_p1;
  assign o_instr = r_instr_p1;
  assign o_pc    = r_pc_p1;
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, skid for stalled returns, redirect drain and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  if_stage_if.master         imem,
  input  logic [PC_W-1:0]    i_npc,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_inc,
  output logic               o_ifid_valid,
  output logic [INSTR_W-1:0] o_ifid_instr,
  output logic [PC_W-1:0]    o_ifid_pc
);
  fetch_state_t       r_state;
  logic               r_req;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_redir;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic               w_load;
  logic               w_clear;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [PC_W-1:0]    w_ld_pc;

  // r_req is the registered request; rst only masks it so the reset cycle never requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_req        <= 1'b1;
      r_pc         <= RESET_PC;
      r_redir      <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (i_flush) begin
            if (imem.imem_ack) begin
              r_pc <= i_npc;
            end else begin
              r_redir <= i_npc;
              r_state <= ST_DRAIN;
            end
          end else if (imem.imem_ack) begin
            r_pc <= i_npc;
            if (i_stall) begin
              r_skid_instr <= imem.imem_data;
              r_skid_pc    <= r_pc;
              r_req        <= 1'b0;
              r_state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_flush) begin
            r_pc    <= i_npc;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end else if (!i_stall) begin
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // The abandoned request must complete before the redirect target is fetched.
          if (imem.imem_ack) begin
            r_pc    <= i_flush ? i_npc : r_redir;
            r_state <= ST_FETCH;
          end else if (i_flush) begin
            r_redir <= i_npc;
          end
        end
        default: begin
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req & ~rst;
  assign imem.imem_addr = r_pc;
  assign o_pc           = r_pc;
  assign o_pc_inc       = r_pc + PC_W'(1);

  always_comb begin
    w_load     = 1'b0;
    w_ld_instr = imem.imem_data;
    w_ld_pc    = r_pc;
    if (r_state == ST_HOLD) begin
      w_load     = 1'b1;
      w_ld_instr = r_skid_instr;
      w_ld_pc    = r_skid_pc;
    end else if (r_state == ST_FETCH) begin
      w_load     = imem.imem_ack;
    end
  end

  assign w_clear = i_flush;

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_hold  (i_stall),
    .i_clear (w_clear),
    .i_instr (w_ld_instr),
    .i_pc    (w_ld_pc),
    .o_valid (o_ifid_valid),
    .o_instr (o_ifid_instr),
    .o_pc    (o_ifid_pc)
  );
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then random traffic vs a flag-based model.
module tb_if_stage;
  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic        ack_i;
  logic [11:0] npc_i;
  logic [11:0] pc_o;
  logic [11:0] pc_inc_o;
  logic        ifid_valid_o;
  logic [15:0] ifid_instr_o;
  logic [11:0] ifid_pc_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  if_stage_if #(.PC_W(12), .INSTR_W(16)) bus ();

  if_stage #(.PC_W(12), .INSTR_W(16), .RESET_PC(12'h000)) dut (
    .clk          (clk),
    .rst          (rst_i),
    .imem         (bus),
    .i_npc        (npc_i),
    .i_stall      (stall_i),
    .i_flush      (flush_i),
    .o_pc         (pc_o),
    .o_pc_inc     (pc_inc_o),
    .o_ifid_valid (ifid_valid_o),
    .o_ifid_instr (ifid_instr_o),
    .o_ifid_pc    (ifid_pc_o)
  );

  function automatic logic [15:0] memf(input logic [11:0] a);
    return 16'hA000 ^ {4'h0, a};
  endfunction

  assign bus.imem_ack  = ack_i;
  assign bus.imem_data = memf(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a fetch either flows on, waits in a "held" slot for decode, or is being abandoned.
  logic [11:0] m_pc;
  bit          m_held;
  logic [15:0] m_held_instr;
  logic [11:0] m_held_pc;
  bit          m_redir_pend;
  logic [11:0] m_redir_tgt;
  bit          m_v;
  logic [15:0] m_instr;
  logic [11:0] m_ipc;

  function automatic bit exp_req();
    return !rst_i && !m_held;
  endfunction

  function void model_step();
    if (rst_i) begin
      m_pc = 12'h000; m_held = 0; m_redir_pend = 0;
      m_v = 0; m_instr = '0; m_ipc = '0;
    end else if (m_held) begin
      if (flush_i) begin
        m_held = 0; m_pc = npc_i; m_v = 0;
      end else if (!stall_i) begin
        m_held = 0; m_v = 1; m_instr = m_held_instr; m_ipc = m_held_pc;
      end
    end else if (m_redir_pend) begin
      if (flush_i || !stall_i) m_v = 0;
      if (ack_i) begin
        m_pc = flush_i ? npc_i : m_redir_tgt;
        m_redir_pend = 0;
      end else if (flush_i) begin
        m_redir_tgt = npc_i;
      end
    end else begin
      if (flush_i) begin
        m_v = 0;
        if (ack_i) m_pc = npc_i;
        else begin m_redir_pend = 1; m_redir_tgt = npc_i; end
      end else if (ack_i) begin
        if (stall_i) begin
          m_held = 1; m_held_instr = memf(m_pc); m_held_pc = m_pc;
        end else begin
          m_v = 1; m_instr = memf(m_pc); m_ipc = m_pc;
        end
        m_pc = npc_i;
      end else if (!stall_i) begin
        m_v = 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic f, input logic a,
                     input logic [11:0] n);
    rst_i = r; stall_i = s; flush_i = f; ack_i = a; npc_i = n;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",    32'(bus.imem_req),  32'(exp_req()));
      chk("addr",   32'(bus.imem_addr), 32'(m_pc));
      chk("pc",     32'(pc_o),          32'(m_pc));
      chk("pc_inc", 32'(pc_inc_o),      32'(12'(m_pc + 12'd1)));
      chk("valid",  32'(ifid_valid_o),  32'(m_v));
      if (m_v) begin
        chk("ifid_instr", 32'(ifid_instr_o), 32'(m_instr));
        chk("ifid_pc",    32'(ifid_pc_o),    32'(m_ipc));
      end
    end
  end

  initial begin
    rst_i = 1; stall_i = 0; flush_i = 0; ack_i = 0; npc_i = '0;
    m_pc = '0; m_held = 0; m_held_instr = '0; m_held_pc = '0;
    m_redir_pend = 0; m_redir_tgt = '0; m_v = 0; m_instr = '0; m_ipc = '0;

    // Reset, with an ack offered during reset that must be ignored.
    cyc(1, 0, 0, 1, 12'h000);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 12'h000);
    chk("rst_req",   32'(bus.imem_req), 32'h0);
    chk("rst_pc",    32'(pc_o),         32'h000);
    chk("rst_valid", 32'(ifid_valid_o), 32'h0);
    chk("rst_instr", 32'(ifid_instr_o), 32'h0);
    chk("rst_ifpc",  32'(ifid_pc_o),    32'h0);
    rst_i = 0; #1;
    chk("req_after_rst", 32'(bus.imem_req), 32'h1);

    // Back-to-back zero-latency fetches.
    cyc(0, 0, 0, 1, 12'h001);
    chk("seq0_pc",    32'(ifid_pc_o),    32'h000);
    chk("seq0_instr", 32'(ifid_instr_o), 32'hA000);
    cyc(0, 0, 0, 1, 12'h002);
    chk("seq1_pc",    32'(ifid_pc_o),    32'h001);
    cyc(0, 0, 0, 1, 12'h003);
    chk("seq2_pc",    32'(ifid_pc_o),    32'h002);
    chk("seq2_instr", 32'(ifid_instr_o), 32'hA002);
    cyc(0, 0, 0, 1, 12'h004);
    cyc(0, 0, 0, 1, 12'h005);

    // Ack at 005 under a three-cycle stall.
    cyc(0, 1, 0, 1, 12'h006);
    chk("stall_pc",   32'(pc_o),         32'h006);
    chk("stall_req",  32'(bus.imem_req), 32'h0);
    chk("stall_ifpc", 32'(ifid_pc_o),    32'h004);
    cyc(0, 1, 0, 0, 12'h006);
    cyc(0, 1, 0, 0, 12'h006);
    chk("stall3_req",  32'(bus.imem_req), 32'h0);
    chk("stall3_ifpc", 32'(ifid_pc_o),    32'h004);
    chk("stall3_pc",   32'(pc_o),         32'h006);
    cyc(0, 0, 0, 0, 12'h006);
    chk("unstall_ifpc",  32'(ifid_pc_o),    32'h005);
    chk("unstall_instr", 32'(ifid_instr_o), 32'hA005);
    chk("unstall_valid", 32'(ifid_valid_o), 32'h1);

    // Flush while the request at 006 is outstanding; ack two cycles later.
    cyc(0, 0, 1, 0, 12'h0A0);
    chk("drain_addr0",  32'(bus.imem_addr), 32'h006);
    chk("drain_valid0", 32'(ifid_valid_o),  32'h0);
    cyc(0, 0, 0, 0, 12'h007);
    chk("drain_addr1",  32'(bus.imem_addr), 32'h006);
    chk("drain_valid1", 32'(ifid_valid_o),  32'h0);
    cyc(0, 0, 0, 1, 12'h007);
    chk("redir_addr",  32'(bus.imem_addr), 32'h0A0);
    chk("redir_valid", 32'(ifid_valid_o),  32'h0);

    // Flush together with stall while holding a skid entry.
    cyc(0, 1, 0, 1, 12'h0A1);
    chk("hold_req", 32'(bus.imem_req), 32'h0);
    cyc(0, 1, 1, 0, 12'h020);
    chk("hflush_valid", 32'(ifid_valid_o),  32'h0);
    chk("hflush_pc",    32'(pc_o),          32'h020);
    chk("hflush_req",   32'(bus.imem_req),  32'h1);
    cyc(0, 0, 0, 1, 12'h021);
    chk("hflush_ifpc", 32'(ifid_pc_o), 32'h020);

    // PC wrap at FFF.
    cyc(0, 0, 0, 1, 12'hFFF);
    chk("wrap_inc", 32'(pc_inc_o), 32'h000);
    cyc(0, 0, 0, 1, 12'h000);
    chk("wrap_pc",    32'(pc_o),      32'h000);
    chk("wrap_ifpc",  32'(ifid_pc_o), 32'hFFF);

    // Reset asserted in DRAIN with an ack in the same cycle.
    cyc(0, 0, 1, 0, 12'h123);
    cyc(1, 0, 0, 1, 12'h055);
    chk("drst_pc",    32'(pc_o),         32'h000);
    chk("drst_valid", 32'(ifid_valid_o), 32'h0);
    chk("drst_req",   32'(bus.imem_req), 32'h0);
    rst_i = 0; #1;
    chk("drst_req1",  32'(bus.imem_req),  32'h1);
    chk("drst_addr",  32'(bus.imem_addr), 32'h000);
    cyc(0, 0, 0, 1, 12'h001);
    chk("drst_ifpc",  32'(ifid_pc_o),    32'h000);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, f, a;
      logic [11:0] n;
      r = ($urandom_range(99) == 0);
      s = ($urandom_range(99) < 30);
      f = ($urandom_range(99) < 10);
      if (r) a = 1'($urandom_range(1));
      else   a = (!m_held) && ($urandom_range(99) < 55);
      n = ($urandom_range(4) == 0) ? 12'($urandom) : 12'(m_pc + 12'd1);
      cyc(r, s, f, a, n);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_W, default 12, width of program counter and instruction address.
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 12'h000, PC value loaded by reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 npc  input  PC_W  next PC from the PC select mux; already chooses between branch target and pc_inc.
REQ-007 stall  input  1  decode cannot accept; hold IF/ID register.
REQ-008 flush  input  1  redirect (taken branch); discard current fetch and IF/ID contents.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  PC_W  fetch address; equals pc.
REQ-011 imem_ack  input  1  memory returns imem_data this cycle; variable latency, at least 0 cycles after req.
REQ-012 imem_data  input  INSTR_W  fetched instruction, valid only with imem_ack.
REQ-013 pc  output  PC_W  current fetch PC.
REQ-014 pc_inc  output  PC_W  pc+1 mod 2^PC_W, combinational, fed to the mux.
REQ-015 ifid_valid, ifid_instr (INSTR_W), ifid_pc (PC_W)  outputs  IF/ID pipeline register.

Function
REQ-016 States: FETCH, HOLD, DRAIN.
REQ-017 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD and during reset cycle.
REQ-018 imem_addr SHALL remain stable from req assertion until imem_ack.
REQ-019 FETCH, ack, !stall, !flush: ifid <= {1, imem_data, pc}; pc <= npc; stay FETCH; one fetch per cycle under zero-latency memory.
REQ-020 FETCH, ack, stall, !flush: imem_data and pc captured into skid register; pc <= npc; go HOLD; IF/ID unchanged.
REQ-021 HOLD, !stall, !flush: ifid <= skid contents with valid=1; go FETCH.
REQ-022 FETCH, no ack, !flush: pc and IF/ID unchanged; if !stall and IF/ID not refilled, ifid_valid <= 0 (bubble).
REQ-023 stall=1 SHALL hold ifid_valid/instr/pc unchanged in every state unless flush.
REQ-024 flush dominates stall; on flush ifid_valid <= 0 next cycle.
REQ-025 FETCH, flush, ack: returned data discarded; pc <= npc; stay FETCH.
REQ-026 FETCH, flush, no ack: redir <= npc; go DRAIN; pc unchanged (REQ-018).
REQ-027 DRAIN, ack: data discarded; pc <= redir; go FETCH. DRAIN, flush again: redir <= npc (latest wins).
REQ-028 HOLD, flush: skid discarded; pc <= npc; go FETCH.
REQ-029 PC arithmetic modulo 2^PC_W; pc_inc of 12'hFFF is 12'h000.

Reset
REQ-030 rst SHALL override all inputs in the cycle it is sampled, including mid-request or in HOLD/DRAIN.
REQ-031 After reset: state FETCH, pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, skid and redir cleared; imem_req=1 from first cycle after rst deasserts.
REQ-032 An imem_ack arriving in the reset cycle SHALL be ignored.

Structure
REQ-033 Shared package holds PC_W, INSTR_W, RESET_PC defaults and state encoding typedef.
REQ-034 One sub-module: ifid_reg (pipeline register with load, hold, clear; clear beats hold).
REQ-035 PC register, skid, redir and FSM reside in if_stage; no latches, no combinational path ack->imem_req.

Verification
REQ-036 Reset, ack every cycle, no stall/flush, npc=pc_inc -> ifid_pc 000,001,002 on consecutive cycles, ifid_instr matches memory.
REQ-037 Ack at pc=005 with stall=1 for 3 cycles -> imem_req 0, IF/ID frozen, pc=006; stall drop -> ifid_pc=005 next cycle.
REQ-038 Flush with npc=0A0 while req pending, ack 2 cycles later -> imem_addr stays old pc until ack, data dropped, next imem_addr=0A0, ifid_valid 0 throughout.
REQ-039 Flush and stall together in HOLD with npc=020 -> ifid_valid=0, skid dropped, pc=020, state FETCH.
REQ-040 pc=FFF fetch with npc=pc_inc -> pc wraps to 000.
REQ-041 rst asserted in DRAIN with ack same cycle -> pc=000, ifid_valid=0, ack ignored, fetch restarts at 000.
